// File: rtl/dac_param_sequencer.sv
// dac_param_sequencer: turns timed RTO commands into registered DDS freq/phase/amp words with a linear amplitude ramp
//   in : clk, reset (sync, active-high), cmd_valid, cmd_data ([127:64] timestamp, [63:0] command)
//   out: freq_word, phase_word, amp_word, param_update, ramp_busy, ramp_done, illegal_cmd, last_timestamp
module dac_param_sequencer #(
  parameter int AMP_W = 14,
  parameter int FREQ_W = 48,
  parameter int PHASE_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  input  logic [127:0]       cmd_data,
  output logic [FREQ_W-1:0]  freq_word,
  output logic [PHASE_W-1:0] phase_word,
  output logic [AMP_W-1:0]   amp_word,
  output logic               param_update,
  output logic               ramp_busy,
  output logic               ramp_done,
  output logic               illegal_cmd,
  output logic [63:0]        last_timestamp
);
  typedef enum logic {IDLE, WAIT} state_t;
  state_t state_q, state_d;
  logic [FREQ_W-1:0] freq_q, freq_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [AMP_W-1:0] amp_q, amp_d, tgt_q, tgt_d, step_q, step_d, stepped, c_tgt, c_step;
  logic [15:0] timer_q, timer_d, ival_q, ival_d, c_ival;
  logic [63:0] ts_q, ts_d;
  logic up_q, up_d, upd_q, upd_d, done_q, done_d, ill_q, ill_d, step_now, unused_bits;
  logic [AMP_W:0] sum, diff;
  logic [3:0] op;
  assign op = cmd_data[63:60];
  assign c_tgt = cmd_data[AMP_W-1:0];
  assign c_step = cmd_data[16 +: AMP_W];
  assign c_ival = cmd_data[47:32] == 16'd0 ? 16'd0 : cmd_data[47:32] - 16'd1;
  assign unused_bits = ^cmd_data[59:48];
  // The last WAIT cycle doubles as the STEP cycle, so steps land exactly every interval cycles.
  assign step_now = state_q == WAIT && timer_q == 16'd0;
  // One extra bit catches overflow above max and borrow below zero; both clamp to target.
  assign sum = {1'b0, amp_q} + {1'b0, step_q};
  assign diff = {1'b0, amp_q} - {1'b0, step_q};
  assign stepped = up_q ? (sum >= {1'b0, tgt_q} ? tgt_q : sum[AMP_W-1:0])
                        : (diff[AMP_W] || diff[AMP_W-1:0] <= tgt_q ? tgt_q : diff[AMP_W-1:0]);
  always_comb begin
    state_d = state_q;
    freq_d = freq_q;
    phase_d = phase_q;
    amp_d = amp_q;
    tgt_d = tgt_q;
    step_d = step_q;
    ival_d = ival_q;
    up_d = up_q;
    ts_d = ts_q;
    timer_d = state_q == WAIT ? timer_q - 16'd1 : timer_q;
    upd_d = 1'b0;
    done_d = 1'b0;
    ill_d = 1'b0;
    if (step_now) begin
      amp_d = stepped;
      upd_d = 1'b1;
      timer_d = ival_q;
      state_d = stepped == tgt_q ? IDLE : WAIT;
      done_d = stepped == tgt_q;
    end
    // A same-cycle command overrides the step for amplitude and ramp control.
    if (cmd_valid) begin
      case (op)
        4'd0: ts_d = cmd_data[127:64];
        4'd1: begin
          freq_d = cmd_data[FREQ_W-1:0];
          upd_d = 1'b1;
          ts_d = cmd_data[127:64];
        end
        4'd2: begin
          phase_d = cmd_data[PHASE_W-1:0];
          upd_d = 1'b1;
          ts_d = cmd_data[127:64];
        end
        4'd3: begin
          amp_d = c_tgt;
          upd_d = 1'b1;
          done_d = 1'b0;
          state_d = IDLE;
          ts_d = cmd_data[127:64];
        end
        4'd4: begin
          if (c_step == '0 && c_tgt != amp_q) begin
            ill_d = 1'b1;
          end else begin
            amp_d = amp_q;
            upd_d = 1'b0;
            done_d = c_tgt == amp_q;
            state_d = c_tgt == amp_q ? IDLE : WAIT;
            tgt_d = c_tgt;
            step_d = c_step;
            up_d = c_tgt > amp_q;
            ival_d = c_ival;
            timer_d = c_ival;
            ts_d = cmd_data[127:64];
          end
        end
        4'd5: begin
          freq_d = '0;
          phase_d = '0;
          amp_d = '0;
          upd_d = 1'b1;
          done_d = 1'b0;
          state_d = IDLE;
          ts_d = cmd_data[127:64];
        end
        default: ill_d = 1'b1;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      freq_q <= '0;
      phase_q <= '0;
      amp_q <= '0;
      tgt_q <= '0;
      step_q <= '0;
      ival_q <= '0;
      timer_q <= '0;
      up_q <= 1'b0;
      ts_q <= '0;
      upd_q <= 1'b0;
      done_q <= 1'b0;
      ill_q <= 1'b0;
    end else begin
      state_q <= state_d;
      freq_q <= freq_d;
      phase_q <= phase_d;
      amp_q <= amp_d;
      tgt_q <= tgt_d;
      step_q <= step_d;
      ival_q <= ival_d;
      timer_q <= timer_d;
      up_q <= up_d;
      ts_q <= ts_d;
      upd_q <= upd_d;
      done_q <= done_d;
      ill_q <= ill_d;
    end
  end
  assign freq_word = freq_q;
  assign phase_word = phase_q;
  assign amp_word = amp_q;
  assign param_update = upd_q;
  assign ramp_busy = state_q == WAIT;
  assign ramp_done = done_q;
  assign illegal_cmd = ill_q;
  assign last_timestamp = ts_q;
endmodule

// File: tb/tb_dac_param_sequencer.sv
// tb_dac_param_sequencer: directed vector table plus randomized run against a behavioural model
module tb_dac_param_sequencer;
  logic clk = 1'b0, reset = 1'b1, cmd_valid = 1'b0;
  logic [127:0] cmd_data = '0;
  logic [47:0] freq_word;
  logic [15:0] phase_word;
  logic [13:0] amp_word;
  logic param_update, ramp_busy, ramp_done, illegal_cmd;
  logic [63:0] last_timestamp;
  int compared = 0, mismatched = 0;
  always #5 clk = ~clk;
  dac_param_sequencer dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_data(cmd_data),
    .freq_word(freq_word), .phase_word(phase_word), .amp_word(amp_word),
    .param_update(param_update), .ramp_busy(ramp_busy), .ramp_done(ramp_done),
    .illegal_cmd(illegal_cmd), .last_timestamp(last_timestamp)
  );
  typedef struct {
    bit r;
    bit v;
    logic [127:0] d;
    logic [47:0] f;
    logic [15:0] p;
    logic [13:0] a;
    bit u, b, dn, il;
    logic [63:0] t;
  } vec_t;
  vec_t tbl[$];
  localparam logic [47:0] F = 48'h123456789ABC;
  function automatic logic [127:0] mk(logic [63:0] ts, logic [3:0] op, logic [59:0] body);
    return {ts, op, body};
  endfunction
  function automatic logic [127:0] ramp(logic [63:0] ts, logic [13:0] tgt, logic [13:0] st, logic [15:0] iv);
    return mk(ts, 4'd4, {12'h0, iv, 2'b0, st, 2'b0, tgt});
  endfunction
  function automatic void row(bit r, bit v, logic [127:0] d, logic [47:0] f, logic [15:0] p, logic [13:0] a,
                              bit u, bit b, bit dn, bit il, logic [63:0] t);
    tbl.push_back('{r, v, d, f, p, a, u, b, dn, il, t});
  endfunction
  task automatic chk(string n, logic [63:0] act, logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask
  task automatic check_all(string tag, logic [47:0] f, logic [15:0] p, logic [13:0] a,
                           bit u, bit b, bit dn, bit il, logic [63:0] t);
    chk({tag, " freq_word"}, 64'(freq_word), 64'(f));
    chk({tag, " phase_word"}, 64'(phase_word), 64'(p));
    chk({tag, " amp_word"}, 64'(amp_word), 64'(a));
    chk({tag, " param_update"}, 64'(param_update), 64'(u));
    chk({tag, " ramp_busy"}, 64'(ramp_busy), 64'(b));
    chk({tag, " ramp_done"}, 64'(ramp_done), 64'(dn));
    chk({tag, " illegal_cmd"}, 64'(illegal_cmd), 64'(il));
    chk({tag, " last_timestamp"}, last_timestamp, t);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  // Behavioural model: amplitude ramps as "every interval cycles move by step, clamped at target".
  logic [47:0] m_freq;
  logic [15:0] m_phase;
  logic [63:0] m_ts;
  int m_amp, m_tgt, m_step, m_int, m_cnt;
  bit m_busy, m_up, m_upd, m_done, m_ill;
  function automatic void model(bit r, bit v, logic [127:0] d);
    int n_amp, op, tgt, st, iv;
    m_upd = 0;
    m_done = 0;
    m_ill = 0;
    if (r) begin
      m_freq = 0; m_phase = 0; m_ts = 0; m_amp = 0; m_busy = 0; m_cnt = 0;
      return;
    end
    n_amp = m_amp;
    if (m_busy) begin
      m_cnt--;
      if (m_cnt == 0) begin
        n_amp = m_up ? ((m_amp + m_step > m_tgt) ? m_tgt : m_amp + m_step)
                     : ((m_amp - m_step < m_tgt) ? m_tgt : m_amp - m_step);
        m_upd = 1;
        m_cnt = m_int;
        if (n_amp == m_tgt) begin
          m_busy = 0;
          m_done = 1;
        end
      end
    end
    if (v) begin
      op = int'(d[63:60]);
      tgt = int'(d[13:0]);
      st = int'(d[29:16]);
      iv = int'(d[47:32]);
      if (op > 5 || (op == 4 && st == 0 && tgt != m_amp)) m_ill = 1;
      else begin
        m_ts = d[127:64];
        if (op == 1) begin m_freq = d[47:0]; m_upd = 1; end
        if (op == 2) begin m_phase = d[15:0]; m_upd = 1; end
        if (op == 3) begin n_amp = tgt; m_upd = 1; m_busy = 0; m_done = 0; end
        if (op == 5) begin m_freq = 0; m_phase = 0; n_amp = 0; m_upd = 1; m_busy = 0; m_done = 0; end
        if (op == 4) begin
          n_amp = m_amp;
          m_upd = 0;
          m_done = tgt == m_amp;
          m_busy = tgt != m_amp;
          m_tgt = tgt;
          m_step = st;
          m_up = tgt > m_amp;
          m_int = iv == 0 ? 1 : iv;
          m_cnt = m_int;
        end
      end
    end
    m_amp = n_amp;
  endfunction
  initial begin
    row(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    row(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    row(0, 1, mk(100, 4'd1, 60'h123456789ABC), F, 0, 0, 1, 0, 0, 0, 100);
    row(0, 0, 0, F, 0, 0, 0, 0, 0, 0, 100);
    row(0, 1, ramp(200, 10, 4, 3), F, 0, 0, 0, 1, 0, 0, 200);
    row(0, 0, 0, F, 0, 0, 0, 1, 0, 0, 200);
    row(0, 0, 0, F, 0, 0, 0, 1, 0, 0, 200);
    row(0, 0, 0, F, 0, 4, 1, 1, 0, 0, 200);
    row(0, 0, 0, F, 0, 4, 0, 1, 0, 0, 200);
    row(0, 0, 0, F, 0, 4, 0, 1, 0, 0, 200);
    row(0, 0, 0, F, 0, 8, 1, 1, 0, 0, 200);
    row(0, 0, 0, F, 0, 8, 0, 1, 0, 0, 200);
    row(0, 0, 0, F, 0, 8, 0, 1, 0, 0, 200);
    row(0, 0, 0, F, 0, 10, 1, 0, 1, 0, 200);
    row(0, 0, 0, F, 0, 10, 0, 0, 0, 0, 200);
    row(0, 1, mk(300, 4'd3, 60'h3FFF), F, 0, 14'h3FFF, 1, 0, 0, 0, 300);
    row(0, 1, ramp(301, 0, 14'h3000, 0), F, 0, 14'h3FFF, 0, 1, 0, 0, 301);
    row(0, 0, 0, F, 0, 14'h0FFF, 1, 1, 0, 0, 301);
    row(0, 0, 0, F, 0, 0, 1, 0, 1, 0, 301);
    row(0, 0, 0, F, 0, 0, 0, 0, 0, 0, 301);
    row(0, 1, ramp(400, 14'h200, 14'h10, 2), F, 0, 0, 0, 1, 0, 0, 400);
    row(0, 0, 0, F, 0, 0, 0, 1, 0, 0, 400);
    row(0, 0, 0, F, 0, 14'h10, 1, 1, 0, 0, 400);
    row(0, 1, mk(401, 4'd3, 60'h100), F, 0, 14'h100, 1, 0, 0, 0, 401);
    for (int i = 0; i < 3; i++) row(0, 0, 0, F, 0, 14'h100, 0, 0, 0, 0, 401);
    row(0, 1, mk(500, 4'd9, 60'h5), F, 0, 14'h100, 0, 0, 0, 1, 401);
    row(0, 1, ramp(501, 5, 0, 1), F, 0, 14'h100, 0, 0, 0, 1, 401);
    row(0, 1, ramp(502, 14'h100, 0, 1), F, 0, 14'h100, 0, 0, 1, 0, 502);
    row(0, 1, ramp(600, 14'h108, 4, 2), F, 0, 14'h100, 0, 1, 0, 0, 600);
    row(0, 0, 0, F, 0, 14'h100, 0, 1, 0, 0, 600);
    row(0, 1, mk(601, 4'd2, 60'h8000), F, 16'h8000, 14'h104, 1, 1, 0, 0, 601);
    row(0, 0, 0, F, 16'h8000, 14'h104, 0, 1, 0, 0, 601);
    row(0, 0, 0, F, 16'h8000, 14'h108, 1, 0, 1, 0, 601);
    row(0, 1, ramp(700, 0, 1, 1), F, 16'h8000, 14'h108, 0, 1, 0, 0, 700);
    row(0, 0, 0, F, 16'h8000, 14'h107, 1, 1, 0, 0, 700);
    row(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    row(0, 1, mk(800, 4'd0, 60'h1), 0, 0, 0, 0, 0, 0, 0, 800);
    row(0, 1, mk(801, 4'd1, 60'h5), 48'h5, 0, 0, 1, 0, 0, 0, 801);
    row(0, 1, mk(802, 4'd3, 60'h77), 48'h5, 0, 14'h77, 1, 0, 0, 0, 802);
    row(0, 1, mk(803, 4'd5, 60'hFFF), 0, 0, 0, 1, 0, 0, 0, 803);
    for (int i = 0; i < tbl.size(); i++) begin
      reset = tbl[i].r;
      cmd_valid = tbl[i].v;
      cmd_data = tbl[i].d;
      tick();
      check_all($sformatf("vec%0d", i), tbl[i].f, tbl[i].p, tbl[i].a, tbl[i].u, tbl[i].b, tbl[i].dn, tbl[i].il, tbl[i].t);
    end
    reset = 1;
    cmd_valid = 0;
    model(1, 0, 0);
    tick();
    for (int c = 0; c < 4000; c++) begin
      int op, sel;
      logic [13:0] tgt, st;
      logic [15:0] iv;
      logic [63:0] ts;
      reset = $urandom_range(0, 299) == 0;
      cmd_valid = $urandom_range(0, 1) == 1;
      sel = $urandom_range(0, 19);
      op = sel < 17 ? sel % 6 : $urandom_range(6, 15);
      tgt = $urandom_range(0, 3) == 0 ? 14'(m_amp) : 14'($urandom);
      sel = $urandom_range(0, 11);
      st = sel < 2 ? 14'd0 : sel < 5 ? 14'($urandom) : 14'($urandom_range(1, 300));
      iv = 16'($urandom_range(0, 3));
      ts = {$urandom, $urandom};
      cmd_data = op == 4 ? ramp(ts, tgt, st, iv) : mk(ts, 4'(op), {28'($urandom), $urandom});
      model(reset, cmd_valid, cmd_data);
      tick();
      check_all($sformatf("rnd%0d", c), m_freq, m_phase, 14'(m_amp), m_upd, m_busy, m_done, m_ill, m_ts);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/dac_param_sequencer.md
# dac_param_sequencer

- Sits directly downstream of the DAC controller's real-time output (RTO) core.
- Takes the one-cycle `cmd_valid` strobe and the 128-bit timed word the RTO core releases when its timestamp matches the system counter.
- Decodes the lower 64 bits into DDS parameter updates: frequency, phase, amplitude, and a linear amplitude ramp.
- Holds the parameters as registered outputs for the DAC datapath.

## Interface
Parameters:
- `AMP_W`, 14, amplitude word width.
- `FREQ_W`, 48, frequency tuning word width.
- `PHASE_W`, 16, phase offset word width.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  one-cycle strobe from the RTO core when its timestamp matches.
- `cmd_data`  in  128  [127:64] timestamp, [63:0] command.
- `freq_word`  out  FREQ_W  current frequency tuning word.
- `phase_word`  out  PHASE_W  current phase offset.
- `amp_word`  out  AMP_W  current amplitude (unsigned).
- `param_update`  out  1  one-cycle pulse whenever any of freq/phase/amp changes value or is written.
- `ramp_busy`  out  1  high while an amplitude ramp is in progress.
- `ramp_done`  out  1  one-cycle pulse on the cycle the ramp reaches its target.
- `illegal_cmd`  out  1  one-cycle pulse on an undefined opcode or invalid ramp.
- `last_timestamp`  out  64  timestamp of the last accepted command.

## Operation
- Opcode is `cmd_data[63:60]`. Only cycles with `cmd_valid`=1 are decoded.
  - 0 NOP: updates `last_timestamp` only; no `param_update`.
  - 1 SET_FREQ: `freq_word` <= `cmd_data[47:0]`.
  - 2 SET_PHASE: `phase_word` <= `cmd_data[15:0]`.
  - 3 SET_AMP: `amp_word` <= `cmd_data[13:0]`. Aborts any ramp: `ramp_busy`->0, no `ramp_done`.
  - 4 RAMP_AMP:
    - Fields: target = `[13:0]`, step = `[29:16]` (14-bit magnitude), interval = `[47:32]` cycles. Interval 0 is treated as 1.
    - Aborts any active ramp and starts a new one from the current `amp_word`.
  - 5 CLEAR: freq/phase/amp <= 0; ramp aborted.
  - 6..15: `illegal_cmd` pulse. No state change; `last_timestamp` is not updated.
- RAMP_AMP with step=0 and target≠`amp_word` is illegal: `illegal_cmd` pulse, no ramp, prior ramp untouched.
- RAMP_AMP with target==`amp_word`: no ramp, `ramp_done` pulse, `ramp_busy` stays 0.
- Ramp FSM states:
  - IDLE -> WAIT on a valid RAMP_AMP.
  - WAIT: timer counts down from interval-1. When timer==0, go to STEP.
  - STEP: apply one step, then return to WAIT (timer reloaded) or go to IDLE if the target is reached.
  - STEP merges into the WAIT timer-expiry cycle (no extra cycle).
- Step arithmetic:
  - Direction is up if target > `amp_word`, else down.
  - Computed at AMP_W+1 bits; the result saturates to target (never overshoots, never wraps past 0 or max).
- Every accepted opcode 0–5 latches `last_timestamp` <= `cmd_data[127:64]`.

## Timing
- Reset values: `freq_word`, `phase_word`, `amp_word`, `last_timestamp` = 0. `param_update`, `ramp_busy`, `ramp_done`, `illegal_cmd` = 0. FSM = IDLE.
- Reset mid-ramp: the ramp stops immediately and all outputs return to reset values on the next edge.
- Command latency: `cmd_valid` sampled at edge N -> outputs and pulses valid after edge N (1 cycle, fully registered).
- Ramp latency:
  - Ramp accepted at edge N: `ramp_busy`=1 from edge N.
  - First amplitude step appears at edge N+interval, then every interval cycles.
  - On the final step edge, `amp_word`=target, `ramp_busy`->0 and `ramp_done`=1 together.
- Each ramp step asserts `param_update` for one cycle.
- Back-to-back commands on consecutive cycles are all accepted; there is no backpressure.
- A ramp step and a command on the same edge: the command wins for amplitude (SET_AMP/CLEAR/RAMP_AMP). SET_FREQ/SET_PHASE coexist with the step and produce one `param_update` pulse.

## Test plan
- Reset: assert `reset` 2 cycles -> all outputs 0. SET_FREQ 0x123456789ABC at ts 100 -> `freq_word`=0x123456789ABC, `param_update` pulse, `last_timestamp`=100, one cycle later.
- Ramp up: `amp_word`=0, RAMP_AMP target=10, step=4, interval=3 -> `amp_word` 4,8,10 at +3,+6,+9 cycles; `ramp_done` at +9; `ramp_busy` high from +0 through +8.
- Ramp down with saturation:
  - Case 1: `amp_word`=0x3FFF, RAMP_AMP target=0, step=0x3000, interval=0 -> 0x0FFF at +1, 0 at +2, then `ramp_done`.
  - Case 2: `amp_word` never wraps.
- Abort: start RAMP_AMP, then SET_AMP 0x100 mid-ramp -> `amp_word`=0x100, `ramp_busy`=0, no `ramp_done`, no further steps.
- Illegal handling:
  - Opcode 9 -> `illegal_cmd` pulse; outputs and `last_timestamp` unchanged.
  - RAMP_AMP step=0 with target≠amp -> `illegal_cmd`, no ramp.
  - RAMP_AMP with target==amp -> `ramp_done` only.
- Collision: a ramp step edge coincides with SET_PHASE 0x8000 -> both applied, single `param_update` pulse. Reset asserted mid-ramp -> all zero next cycle.
